bcd_to_excess3_serial: RTL and testbench

- Serial converter from BCD to Excess-3, the encoder that feeds the Excess-3 to BCD serial converter.
- One 4-bit digit enters on X, LSB first, one bit per enabled clock.
- Each Excess-3 bit leaves on Z in the same cycle: Mealy output, zero latency.
- Also flags the last bit of each digit and invalid BCD codes (10..15).

---
 rtl/bcd_to_excess3_serial_pkg.sv | 21 ++
 rtl/bcd_to_excess3_serial_add_cell.sv | 16 +
 rtl/bcd_to_excess3_serial.sv | 83 ++++++++
 tb/tb_bcd_to_excess3_serial.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bcd_to_excess3_serial_pkg.sv
// Shared constants for the serial BCD -> Excess-3 encoder.
package bcd_to_excess3_serial_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;   // digits above this are invalid BCD
    localparam int MAX_CODE = (1 << DIGIT_W) - 1;

    // Bit index within the current digit, LSB first.
    typedef enum logic [1:0] {
        BIT0 = 2'd0,
        BIT1 = 2'd1,
        BIT2 = 2'd2,
        BIT3 = 2'd3
    } bit_idx_t;

    // The largest valid digit plus the offset must still fit in one digit.
    function automatic bit offset_ok(input int off);
        return (off >= 0) && (BCD_MAX + off <= MAX_CODE);
    endfunction

endpackage

// File: rtl/bcd_to_excess3_serial_add_cell.sv
// One-bit full adder used as the serial adder slice.
module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/bcd_to_excess3_serial.sv
// Serial BCD to Excess-3 encoder: one digit enters LSB first on X, the
// offset digit leaves on Z in the same cycle (Mealy, zero latency).
module bcd_to_excess3_serial
    import bcd_to_excess3_serial_pkg::*;
#(
    parameter int OFFSET = 3
) (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    input  logic En,
    output logic Z,
    output logic Last,
    output logic Err
);

    // Reject offsets that would overflow a digit for input 9.
    if (!offset_ok(OFFSET)) begin : g_bad_offset
        $error("bcd_to_excess3_serial: OFFSET must be in 0..6");
    end

    localparam logic [DIGIT_W-1:0] K = DIGIT_W'(OFFSET);

    bit_idx_t pos_q, pos_d;
    logic     c_q, c_d;
    logic     seen_q, seen_d;   // bit 1 or bit 2 of this digit was set

    logic     k;
    logic     sum;
    logic     cout;
    logic     at_last;

    assign k       = K[pos_q];
    assign at_last = (pos_q == BIT3);

    serial_add_cell u_add (
        .a    (X),
        .b    (k),
        .cin  (c_q),
        .s    (sum),
        .cout (cout)
    );

    // State register; reset drops the partial digit back to bit 0.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pos_q  <= BIT0;
            c_q    <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            c_q    <= c_d;
            seen_q <= seen_d;
        end
    end

    // Next state and En-gated Mealy outputs. A digit > 9 has bit 3 set
    // together with bit 1 or bit 2, which is what seen & X tests at bit 3.
    always_comb begin
        pos_d  = pos_q;
        c_d    = c_q;
        seen_d = seen_q;
        Z      = 1'b0;
        Last   = 1'b0;
        Err    = 1'b0;
        if (En) begin
            Z    = sum;
            Last = at_last;
            Err  = at_last & X & seen_q;
            if (at_last) begin
                // Final carry is dropped; next digit starts clean.
                pos_d  = BIT0;
                c_d    = 1'b0;
                seen_d = 1'b0;
            end else begin
                pos_d  = bit_idx_t'(pos_q + 2'd1);
                c_d    = cout;
                seen_d = seen_q | (X & ((pos_q == BIT1) | (pos_q == BIT2)));
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Self-checking bench for the serial BCD -> Excess-3 encoder.
module tb_bcd_to_excess3_serial;

    localparam int OFFSET = 3;

    logic Clk = 1'b0;
    logic Rst;
    logic X;
    logic En;
    logic Z;
    logic Last;
    logic Err;

    int checks = 0;
    int errors = 0;
    int last_cnt = 0;

    bcd_to_excess3_serial #(.OFFSET(OFFSET)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .X    (X),
        .En   (En),
        .Z    (Z),
        .Last (Last),
        .Err  (Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: present a bit, sample at negedge, return at posedge+1.
    task automatic step(input logic x, output logic z, output logic l, output logic e);
        En = 1'b1;
        X  = x;
        @(negedge Clk);
        z = Z; l = Last; e = Err;
        if (Last === 1'b1) last_cnt++;
        @(posedge Clk); #1;
    endtask

    // Idle cycles: outputs must stay low whatever X does.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            En = 1'b0;
            X  = 1'($urandom);
            @(negedge Clk);
            chk("gap_outputs", {29'd0, Z, Last, Err}, 0);
            @(posedge Clk); #1;
        end
    endtask

    // Send one digit and compare against plain arithmetic on the digit.
    task automatic send_digit(input logic [3:0] d, input int gap_at, input int gap_len,
                              input bit rnd_gaps, input string tag);
        logic [3:0] zv, lv, ev;
        logic z, l, e;
        int exp_val;
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) gap(gap_len);
            if (rnd_gaps && ($urandom % 8 == 0)) gap($urandom_range(1, 3));
            step(d[i], z, l, e);
            zv[i] = z; lv[i] = l; ev[i] = e;
        end
        exp_val = (int'(d) + OFFSET) % 16;
        chk({tag, "_z"},    int'(zv), exp_val);
        chk({tag, "_last"}, int'(lv), 'b1000);
        chk({tag, "_err"},  int'(ev), (d > 9) ? 'b1000 : 0);
    endtask

    initial begin
        logic [3:0] d;
        int exp_last;
        Rst = 1'b0; En = 1'b0; X = 1'b0;
        @(posedge Clk); #1;

        // Outputs while held in reset.
        En = 1'b1; X = 1'b1;
        #2;
        chk("rst_z_x1", int'(Z), 1 ^ (OFFSET & 1));
        chk("rst_last", int'(Last), 0);
        chk("rst_err",  int'(Err), 0);
        X = 1'b0;
        #1;
        chk("rst_z_x0", int'(Z), OFFSET & 1);
        En = 1'b0; X = 1'b1;
        #1;
        chk("rst_en0", {29'd0, Z, Last, Err}, 0);
        @(posedge Clk); #1;
        Rst = 1'b1;

        // Directed digits, back to back.
        send_digit(4'b0000, -1, 0, 1'b0, "d0");
        send_digit(4'b1001, -1, 0, 1'b0, "d9");
        send_digit(4'b0101, -1, 0, 1'b0, "d5");
        send_digit(4'b0110, -1, 0, 1'b0, "d6");
        send_digit(4'b1010, -1, 0, 1'b0, "d10");
        send_digit(4'b0010, -1, 0, 1'b0, "d2_after_bad");
        send_digit(4'b1111, -1, 0, 1'b0, "d15");
        send_digit(4'b0111, 2, 3, 1'b0, "d7_gap");

        // Reset pulse between edges after two bits of 1000.
        begin
            logic z, l, e;
            step(1'b0, z, l, e);
            step(1'b0, z, l, e);
            En = 1'b0;
            #2 Rst = 1'b0;
            #2 Rst = 1'b1;
            @(posedge Clk); #1;
        end
        send_digit(4'b0001, -1, 0, 1'b0, "d1_after_rst");

        // Random soak of valid digits with random gaps.
        last_cnt = 0;
        for (int n = 0; n < 10000; n++) begin
            d = 4'($urandom_range(0, 9));
            send_digit(d, -1, 0, 1'b1, "soak");
        end
        exp_last = 10000;
        chk("soak_last_count", last_cnt, exp_last);

        En = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #1500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
